// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: state encoding, defaults and width helpers shared by the memory responder
package mem_resp_pkg;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] DONE = 2'b10;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int WORD_BYTES      = 4;
  localparam int WORD_LSB        = 2;
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: 32-bit word storage with per-byte write strobes and a registered, resettable read port
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_BYTES-1:0] wr_be_i,
  input  logic                  rd_en_i,
  input  logic                  rd_clr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_q;
  // storage contents are never reset; each strobe updates its own byte lane
  always_ff @(posedge clk)
    for (int b = 0; b < WORD_BYTES; b++)
      if (wr_be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  // read register holds its value between accesses; cleared by reset or a rejected access
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_q <= '0;
    else if (rd_clr_i) rd_q <= '0;
    else if (rd_en_i) rd_q <= mem_q[addr_i];
  assign rdata_o = rd_q;
endmodule

// File: rtl/mem_resp.sv
// mem_resp: multicycle memory responder with programmable wait states; MEM_BYTE_WRITE_EN adds byte enables
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = cnt_width(WAIT_CYCLES);
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, err_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q, be_in;
  logic                  accept, access, mis;
  logic                  unused_addr;
`ifdef MEM_BYTE_WRITE_EN
  assign be_in = be;
`else
  assign be_in = 4'b1111;
`endif
  assign unused_addr = ^addr[31:ADDR_WIDTH+WORD_LSB];
  assign mis    = addr[1:0] != 2'b00;
  assign accept = (state_q == IDLE) && req;
  assign access = (state_q == WAIT) && (cnt_q == '0);
  // an unknown req in IDLE resolves to "no request", so flag it loudly in simulation
  ap_req_known: assert property (@(posedge clk) disable iff (rst) state_q == IDLE |-> !$isunknown(req));
  // next state: misaligned requests skip the wait phase and finish with an error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && req) begin
      state_d = mis ? DONE : WAIT;
      cnt_d   = CW'(WAIT_CYCLES);
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == '0) ? DONE : WAIT;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state, counter and the request latched at acceptance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        err_q   <= mis;
        word_q  <= addr[ADDR_WIDTH+WORD_LSB-1:WORD_LSB];
        wdata_q <= wdata;
        be_q    <= be_in;
      end
    end
  mem_array #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_be_i  ({4{access & we_q}} & be_q),
    .rd_en_i  (access & ~we_q),
    .rd_clr_i (accept & mis),
    .addr_i   (word_q),
    .wdata_i  (wdata_q),
    .rdata_o  (rdata)
  );
  assign ready = state_q == DONE;
  assign busy  = state_q != IDLE;
  assign err   = ready & err_q;
endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed bench for mem_resp with a timeline/memory reference model and a per-cycle compare
module tb_mem_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_s [2];
  logic        we_s [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s [2];
  logic [3:0]  be_s [2];
  logic [31:0] rd_s [2];
  logic        rdy [2];
  logic        err_s [2];
  logic        busy_s [2];
  int checks = 0;
  int failures = 0;
  int wcy [2] = '{2, 0};
  // reference model: memory image plus the expected timeline of the outstanding request
  logic [31:0] mdl [2][1024];
  bit          kn [2][1024];
  int          e = 0;
  bit          out_m [2];
  int          acc [2];
  int          rr [2];
  bit          mw [2];
  bit          mmis [2];
  int          mword [2];
  logic [31:0] mwd [2];
  logic [3:0]  mbe [2];
  logic [31:0] mrd [2];
  bit          mchk [2];
  always #5 clk = ~clk;
  mem_resp u0 (
    .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]), .wdata(wd_s[0]),
`ifdef MEM_BYTE_WRITE_EN
    .be(be_s[0]),
`endif
    .rdata(rd_s[0]), .ready(rdy[0]), .err(err_s[0]), .busy(busy_s[0])
  );
  mem_resp #(.WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]), .wdata(wd_s[1]),
`ifdef MEM_BYTE_WRITE_EN
    .be(be_s[1]),
`endif
    .rdata(rd_s[1]), .ready(rdy[1]), .err(err_s[1]), .busy(busy_s[1])
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // model: accept when idle, resolve the access WAIT_CYCLES+1 edges later, forget everything on reset
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int d = 0; d < 2; d++) out_m[d] = 1'b0;
    end else begin
      e++;
      for (int d = 0; d < 2; d++) begin
        if (out_m[d] && e == rr[d] && mw[d] && !mmis[d]) begin
          for (int k = 0; k < 4; k++)
            if (mbe[d][k]) mdl[d][mword[d]][8*k +: 8] = mwd[d][8*k +: 8];
          if (mbe[d] == 4'hF) kn[d][mword[d]] = 1'b1;
        end
        if (req_s[d] === 1'b1 && (!out_m[d] || e > rr[d] + 1)) begin
          out_m[d] = 1'b1;
          acc[d]   = e;
          mmis[d]  = (addr_s[d] % 4) != 0;
          mw[d]    = we_s[d];
          mword[d] = (addr_s[d] / 4) % 1024;
          mwd[d]   = wd_s[d];
`ifdef MEM_BYTE_WRITE_EN
          mbe[d]   = be_s[d];
`else
          mbe[d]   = 4'hF;
`endif
          rr[d]    = e + (mmis[d] ? 0 : wcy[d] + 1);
          mrd[d]   = mmis[d] ? 32'h0 : mdl[d][mword[d]];
          mchk[d]  = mmis[d] || (!we_s[d] && kn[d][mword[d]]);
        end
      end
    end
  // compare: ready/busy every cycle, err and rdata whenever a response is presented
  always @(negedge clk)
    if (!rst)
      for (int d = 0; d < 2; d++) begin
        bit eb, er;
        eb = out_m[d] && e >= acc[d] && e <= rr[d];
        er = out_m[d] && e == rr[d];
        check($sformatf("ready[%0d]@%0d", d, e), rdy[d], er);
        check($sformatf("busy[%0d]@%0d", d, e), busy_s[d], eb);
        if (er) begin
          check($sformatf("err[%0d]@%0d", d, e), err_s[d], mmis[d]);
          if (mchk[d]) check($sformatf("rdata[%0d]@%0d", d, e), rd_s[d], mrd[d]);
        end
      end
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    we_s[d] = w; addr_s[d] = a; wd_s[d] = wd; be_s[d] = b; req_s[d] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req_s[d] = 1'b0; we_s[d] = ~w; addr_s[d] = $urandom; wd_s[d] = $urandom; be_s[d] = 4'hF;
    end while (!rdy[d] && lat < 30);
    rd = rd_s[d];
    er = err_s[d];
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, first, prev, gap, n_rdy;
    logic [31:0] rd;
    logic er;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 0; we_s[d] = 0; addr_s[d] = 0; wd_s[d] = 0; be_s[d] = 4'hF;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", rdy[d], 0);
      check("rst_busy", busy_s[d], 0);
      check("rst_err", err_s[d], 0);
      check("rst_rdata", rd_s[d], 0);
    end
    rst = 1'b0;
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    check("wr10_lat", lat, 4); check("wr10_err", er, 0);
    xfer(0, 0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("rd10_lat", lat, 4); check("rd10_data", rd, 32'hDEADBEEF); check("rd10_err", er, 0);
    xfer(0, 0, 32'h13, 32'h0, 4'hF, lat, rd, er);
    check("mis_lat", lat, 1); check("mis_err", er, 1); check("mis_data", rd, 0);
    xfer(0, 1, 32'h11, 32'h55555555, 4'hF, lat, rd, er);
    check("miswr_lat", lat, 1); check("miswr_err", er, 1);
    xfer(0, 0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("rd10_after_mis", rd, 32'hDEADBEEF);
    xfer(0, 1, 32'h1000, 32'hA5A5A5A5, 4'hF, lat, rd, er);
    xfer(0, 0, 32'h0, 32'h0, 4'hF, lat, rd, er);
    check("wrap_data", rd, 32'hA5A5A5A5);
    xfer(0, 0, 32'hFFFF_F010, 32'h0, 4'hF, lat, rd, er);
    check("wrap_hi_data", rd, 32'hDEADBEEF);
    @(negedge clk);
    we_s[0] = 0; addr_s[0] = 32'h10; req_s[0] = 1'b1;
    first = -1; prev = -1; gap = 0; n_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) req_s[0] = 1'b0;
      if (rdy[0]) begin
        if (first < 0) first = i;
        if (prev >= 0) gap = i - prev;
        prev = i;
        n_rdy++;
      end
    end
    check("b2b_first", first, 3); check("b2b_count", n_rdy, 3); check("b2b_gap", gap, 5);
    xfer(0, 1, 32'h20, 32'h1, 4'hF, lat, rd, er);
    @(negedge clk);
    we_s[0] = 1; addr_s[0] = 32'h20; wd_s[0] = 32'hFFFF0000; req_s[0] = 1'b1;
    @(negedge clk);
    req_s[0] = 1'b0;
    check("mid_busy_pre", busy_s[0], 1);
    #2 rst = 1'b1;
    #1;
    check("mid_ready", rdy[0], 0); check("mid_busy", busy_s[0], 0); check("mid_rdata", rd_s[0], 0);
    @(negedge clk);
    rst = 1'b0;
    xfer(0, 0, 32'h20, 32'h0, 4'hF, lat, rd, er);
    check("mid_old_data", rd, 32'h1); check("mid_rd_lat", lat, 4);
`ifdef MEM_BYTE_WRITE_EN
    xfer(0, 1, 32'h0, 32'h0, 4'hF, lat, rd, er);
    xfer(0, 1, 32'h0, 32'hFFFFFFFF, 4'b0101, lat, rd, er);
    xfer(0, 0, 32'h0, 32'h0, 4'hF, lat, rd, er);
    check("be_data", rd, 32'h00FF00FF);
    xfer(0, 1, 32'h0, 32'h12345678, 4'b0000, lat, rd, er);
    check("be0_lat", lat, 4);
    xfer(0, 0, 32'h0, 32'h0, 4'b0000, lat, rd, er);
    check("be0_data", rd, 32'h00FF00FF);
`endif
    xfer(1, 1, 32'h0, 32'h12345678, 4'hF, lat, rd, er);
    check("w0_wr_lat", lat, 2);
    xfer(1, 0, 32'h0, 32'h0, 4'hF, lat, rd, er);
    check("w0_rd_lat", lat, 2); check("w0_rd_data", rd, 32'h12345678);
    xfer(1, 0, 32'h2, 32'h0, 4'hF, lat, rd, er);
    check("w0_mis_lat", lat, 1); check("w0_mis_err", er, 1); check("w0_mis_data", rd, 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
